pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage 64-bit pipeline. It drives the enable
//  and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Detects load-use hazards, flushes on taken branches and freezes the pipe while a
//  data-memory access in MEM is unacknowledged. Timeout -> sticky error state.
// PARAMETERS
//  REG_W        5   register-index width (rs1/rs2/rd)
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before ERROR (>=2)
//  CNT_W        16  width of stall performance counter
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      async, active-high
//  id_valid       in   1      instruction in ID is valid
//  id_rs1         in   REG_W  ID source reg 1
//  id_rs2         in   REG_W  ID source reg 2
//  idex_memread   in   1      ID/EX holds a load
//  idex_rd        in   REG_W  ID/EX destination reg
//  exmem_memread  in   1      EX/MEM MemRead_out
//  exmem_memwrite in   1      EX/MEM MemWrite_Out
//  mem_ready      in   1      data memory completes access this cycle
//  branch_taken   in   1      EX resolved a taken branch/jump
//  pc_stall       out  1      hold PC
//  ifid_stall     out  1      hold IF/ID
//  idex_stall     out  1      hold ID/EX
//  exmem_stall    out  1      hold EX/MEM
//  ifid_flush     out  1      clear IF/ID to NOP
//  idex_flush     out  1      clear ID/EX controls (bubble)
//  memwb_bubble   out  1      load MEM/WB with RegWrite=0
//  state          out  2      00 RUN, 01 MEM_WAIT, 10 ERROR
//  mem_error      out  1      sticky memory-timeout flag
//  stall_cycles   out  CNT_W  saturating count of cycles with pc_stall=1
// BEHAVIOUR
//  Stall/flush outputs combinational from state + inputs; state, wait_cnt,
//   mem_error, stall_cycles registered.
//  reset=1 (async): state=RUN, wait_cnt=0, mem_error=0, stall_cycles=0. While reset
//   is high: ifid_flush=idex_flush=memwb_bubble=1, all stalls=0.
//  load_use = id_valid & idex_memread & idex_rd!=0 & (idex_rd==id_rs1 | idex_rd==id_rs2).
//  mem_busy = (exmem_memread | exmem_memwrite) & !mem_ready.
//  freeze = pc/ifid/idex/exmem_stall=1, memwb_bubble=1, both flushes=0.
//  RUN, priority high->low:
//   mem_busy: freeze; next MEM_WAIT, wait_cnt<=1.
//   branch_taken: ifid_flush=idex_flush=1, no stalls; stay RUN.
//   load_use: pc_stall=ifid_stall=1, idex_flush=1; stay RUN (1-cycle bubble).
//   else: all outputs 0.
//  MEM_WAIT:
//   mem_ready=0: freeze. wait_cnt++. wait_cnt==MEM_TIMEOUT-1 at the edge ->
//    ERROR, mem_error<=1 (ERROR entered after MEM_TIMEOUT frozen cycles).
//   mem_ready=1: no freeze this cycle. Apply RUN branch/load_use rules. Next RUN,
//    wait_cnt<=0.
//  branch_taken and load_use are ignored while frozen. EX and ID are held, so they
//   re-present after release.
//  ERROR: freeze permanently, mem_error=1; leave only by reset.
//  stall_cycles += 1 each cycle pc_stall=1; saturates at 2^CNT_W-1 (no wrap).
//  Latency: hazard responses same cycle; state change visible next cycle.
// TESTING
//  1 idex_memread=1, idex_rd=5, id_rs1=5, id_valid=1 -> pc_stall=ifid_stall=
//    idex_flush=1 for 1 cycle. Same stimulus with idex_rd=0 -> all outputs 0.
//  2 branch_taken=1 in RUN -> ifid_flush=idex_flush=1, pc_stall=0, stall_cycles unchanged.
//  3 exmem_memread=1, mem_ready low 3 cycles then high -> freeze 3 cycles, state=01
//    after first, stall_cycles=3, back to 00 and outputs 0 on ready cycle.
//  4 mem_ready held 0 for 16 cycles -> state=10, mem_error=1, stalls held.
//    Assert reset -> state=00, mem_error=0, stall_cycles=0 immediately.
//  5 mem_busy+branch_taken+load_use together -> freeze only. On ready cycle with
//    branch+load_use -> flushes only, pc_stall=0.
//  6 reset asserted mid-MEM_WAIT (wait_cnt=7) -> async return to RUN.
//    After release, a new busy access restarts wait_cnt at 1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubbles,
// branch flushes, and a pipeline freeze while a data-memory access in MEM waits.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal flow; hazards resolved in the same cycle
// MEM_WAIT | MEM access outstanding; pipe frozen until mem_ready
// ERROR    | access timed out; pipe frozen until reset
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrlState_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // The entry cycle in RUN is already one frozen cycle, so MEM_WAIT may
  // absorb MEM_TIMEOUT-1 more; the down-counter hits zero on the last one.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 2);

  ctrlState_t        curState, nextState;
  logic [WAIT_W-1:0] waitLeft, waitLeftNext;
  logic              loadUse, memBusy, freeze, hazardsLive;

  assign loadUse = id_valid && idex_memread && (idex_rd != '0) &&
                   ((idex_rd == id_rs1) || (idex_rd == id_rs2));
  assign memBusy = (exmem_memread || exmem_memwrite) && !mem_ready;
  assign state   = curState;

  always_comb begin
    nextState    = curState;
    waitLeftNext = waitLeft;
    freeze       = 1'b0;
    hazardsLive  = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;

    unique case (curState)
      RUN: begin
        if (memBusy) begin
          freeze       = 1'b1;
          nextState    = MEM_WAIT;
          waitLeftNext = WAIT_LOAD;
        end else begin
          hazardsLive = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          freeze = 1'b1;
          if (waitLeft == '0) nextState = ERROR;
          else waitLeftNext = waitLeft - 1'b1;
        end else begin
          hazardsLive  = 1'b1;
          nextState    = RUN;
          waitLeftNext = '0;
        end
      end
      ERROR: freeze = 1'b1;
      default: nextState = RUN;
    endcase

    if (freeze) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (hazardsLive) begin
      if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (loadUse) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end

    // Reset forces NOPs into the pipe regardless of state.
    if (reset) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      idex_stall   = 1'b0;
      exmem_stall  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState     <= RUN;
      waitLeft     <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      curState <= nextState;
      waitLeft <= waitLeftNext;
      if (nextState == ERROR) mem_error <= 1'b1;
      if (pc_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
